hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 98 +++++++++
 tb/tb_hazard_ctrl.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller (stalls, flushes, redirect, multi-cycle MDU occupancy)
//
// Ports:
//   clk, rst                  clock; asynchronous active-high reset
//   id_rs1/id_rs2, id_use_*   ID-stage source registers and their valid bits
//   exe_rd, exe_is_load/mdu   EXE-stage destination and instruction class
//   br_mispredict, br_target  EXE branch resolved wrong and the correct PC
//   dmem_req, dmem_ready      MEM-stage access pending / completing this cycle
//   stall_*, flush_*          per-stage hold and bubble controls
//   redirect_valid/_pc        fetch redirect on mispredict
//   mdu_done                  one-cycle pulse when a mul/div op leaves EXE
//   state                     0 RUN, 1 MEM_WAIT, 2 MDU_BUSY
//
// Build option: define HAZARD_PERF_EN to add perf_stall_cycles and
// perf_flush_events counters.
module hazard_ctrl #(
    parameter int ADDR_WIDTH = 16,
    parameter int MDU_LAT    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            id_rs1,
    input  logic [4:0]            id_rs2,
    input  logic                  id_use_rs1,
    input  logic                  id_use_rs2,
    input  logic [4:0]            exe_rd,
    input  logic                  exe_is_load,
    input  logic                  exe_is_mdu,
    input  logic                  br_mispredict,
    input  logic [ADDR_WIDTH-1:0] br_target,
    input  logic                  dmem_req,
    input  logic                  dmem_ready,
    output logic                  stall_if,
    output logic                  stall_id,
    output logic                  stall_exe,
    output logic                  stall_mem,
    output logic                  flush_id,
    output logic                  flush_exe,
    output logic                  flush_mem,
    output logic                  redirect_valid,
    output logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  mdu_done,
    output logic [1:0]            state
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0]           perf_stall_cycles,
    output logic [31:0]           perf_flush_events
`endif
);
    typedef enum logic [1:0] {RUN = 2'd0, MEM_WAIT = 2'd1, MDU_BUSY = 2'd2} state_t;
    state_t     st;
    logic [7:0] cnt;
    logic       mem_hold, mispredict, mdu_start, load_use, mdu_busy, mdu_fin, raw_hit;
    always_comb begin
        // MDU_BUSY masks memory, branch and load-use terms entirely
        mem_hold   = (st != MDU_BUSY) & dmem_req & ~dmem_ready;
        // a mispredict is honoured in RUN and in the MEM_WAIT release cycle
        mispredict = (st != MDU_BUSY) & ~mem_hold & br_mispredict;
        mdu_start  = (st == RUN) & ~mem_hold & ~br_mispredict & exe_is_mdu;
        raw_hit    = (id_use_rs1 & (id_rs1 == exe_rd)) | (id_use_rs2 & (id_rs2 == exe_rd));
        load_use   = (st == RUN) & ~mem_hold & ~br_mispredict & ~exe_is_mdu &
                     exe_is_load & (exe_rd != 5'd0) & raw_hit;
        mdu_busy   = (st == MDU_BUSY) & (cnt != 8'd0);
        mdu_fin    = (st == MDU_BUSY) & (cnt == 8'd0);
        stall_if       = ~rst & (mem_hold | mdu_start | mdu_busy | load_use);
        stall_id       = ~rst & (mem_hold | mdu_start | mdu_busy | load_use);
        stall_exe      = ~rst & (mem_hold | mdu_start | mdu_busy);
        stall_mem      = ~rst & mem_hold;
        flush_id       = ~rst & mispredict;
        flush_exe      = ~rst & (mispredict | load_use);
        flush_mem      = ~rst & (mdu_start | mdu_busy);
        redirect_valid = ~rst & mispredict;
        redirect_pc    = redirect_valid ? br_target : '0;
        mdu_done       = ~rst & mdu_fin;
        state          = rst ? 2'd0 : st;
    end
    // start cycle plus MDU_LAT-2 counted cycles stall; the count-zero cycle completes
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st  <= RUN;
            cnt <= 8'd0;
        end else begin
            st  <= mem_hold ? MEM_WAIT : (mdu_start | mdu_busy) ? MDU_BUSY : RUN;
            cnt <= mdu_start ? 8'(MDU_LAT - 2) : mdu_busy ? cnt - 8'd1 : 8'd0;
        end
    end
`ifdef HAZARD_PERF_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_stall_cycles <= 32'd0;
            perf_flush_events <= 32'd0;
        end else begin
            perf_stall_cycles <= perf_stall_cycles + {31'd0, stall_if};
            perf_flush_events <= perf_flush_events + {31'd0, flush_id | flush_exe | flush_mem};
        end
    end
`endif
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: table-driven and sequence checks for hazard_ctrl
module tb_hazard_ctrl;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [4:0]  id_rs1, id_rs2, exe_rd;
    logic        id_use_rs1, id_use_rs2, exe_is_load, exe_is_mdu, br_mispredict;
    logic [15:0] br_target;
    logic        dmem_req, dmem_ready;
    logic        stall_if, stall_id, stall_exe, stall_mem;
    logic        flush_id, flush_exe, flush_mem, redirect_valid, mdu_done;
    logic [15:0] redirect_pc;
    logic [1:0]  state;
`ifdef HAZARD_PERF_EN
    logic [31:0] perf_stall_cycles, perf_flush_events;
`endif
    int pass_n = 0;
    int total_n = 0;
    logic [8:0] flags;
    // flag order: stall_if stall_id stall_exe stall_mem flush_id flush_exe flush_mem redirect_valid mdu_done
    localparam logic [8:0] NO = 9'b000000000;
    localparam logic [8:0] LU = 9'b110001000;
    localparam logic [8:0] MP = 9'b000011010;
    localparam logic [8:0] MD = 9'b111000100;
    localparam logic [8:0] MH = 9'b111100000;
    localparam logic [8:0] DN = 9'b000000001;

    hazard_ctrl #(.ADDR_WIDTH(16), .MDU_LAT(8)) dut (
        .clk(clk), .rst(rst),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2),
        .exe_rd(exe_rd), .exe_is_load(exe_is_load), .exe_is_mdu(exe_is_mdu),
        .br_mispredict(br_mispredict), .br_target(br_target),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready),
        .stall_if(stall_if), .stall_id(stall_id), .stall_exe(stall_exe), .stall_mem(stall_mem),
        .flush_id(flush_id), .flush_exe(flush_exe), .flush_mem(flush_mem),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .mdu_done(mdu_done), .state(state)
`ifdef HAZARD_PERF_EN
        , .perf_stall_cycles(perf_stall_cycles), .perf_flush_events(perf_flush_events)
`endif
    );

    always #5 clk = ~clk;
    assign flags = {stall_if, stall_id, stall_exe, stall_mem, flush_id, flush_exe, flush_mem,
                    redirect_valid, mdu_done};

    typedef struct {
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd;
        logic        ld, mdu, bm;
        logic [15:0] tgt;
        logic        req, rdy;
        logic [8:0]  ef;
        logic [15:0] epc;
    } vec_t;
    vec_t v[14];

    task automatic chk(input string nm, input logic [8:0] ef, input logic [15:0] epc,
                       input logic [1:0] est);
        total_n++;
        if ({flags, redirect_pc, state} === {ef, epc, est}) pass_n++;
        else $display("FAIL %s: got flags=%b pc=%h state=%0d, want flags=%b pc=%h state=%0d",
                      nm, flags, redirect_pc, state, ef, epc, est);
    endtask

    task automatic clr();
        id_rs1 = 0; id_rs2 = 0; id_use_rs1 = 0; id_use_rs2 = 0; exe_rd = 0;
        exe_is_load = 0; exe_is_mdu = 0; br_mispredict = 0; br_target = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_rst();
        rst = 1'b1;
        #1;
        rst = 1'b0;
    endtask

    initial begin
        clr();
        br_mispredict = 1; br_target = 16'h0040; exe_is_mdu = 1; dmem_req = 1;
        #2;
        chk("reset_outputs_zero", NO, 16'h0, 2'd0);
        rst = 1'b0;
        clr();
        v[0]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 16'h0,    0, 0, NO, 16'h0};
        v[1]  = '{5'd0, 5'd5, 0, 1, 5'd5, 1, 0, 0, 16'h0,    0, 0, LU, 16'h0};
        v[2]  = '{5'd0, 5'd0, 0, 1, 5'd0, 1, 0, 0, 16'h0,    0, 0, NO, 16'h0};
        v[3]  = '{5'd7, 5'd0, 1, 0, 5'd7, 1, 0, 0, 16'h0,    0, 0, LU, 16'h0};
        v[4]  = '{5'd7, 5'd0, 0, 0, 5'd7, 1, 0, 0, 16'h0,    0, 0, NO, 16'h0};
        v[5]  = '{5'd7, 5'd7, 1, 1, 5'd7, 0, 0, 0, 16'h0,    0, 0, NO, 16'h0};
        v[6]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 16'h0040, 0, 0, MP, 16'h0040};
        v[7]  = '{5'd3, 5'd0, 1, 0, 5'd3, 1, 0, 1, 16'h1234, 0, 0, MP, 16'h1234};
        v[8]  = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 0, 16'h0,    0, 0, MD, 16'h0};
        v[9]  = '{5'd9, 5'd0, 1, 0, 5'd9, 1, 1, 0, 16'h0,    0, 0, MD, 16'h0};
        v[10] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 1, 1, 16'hBEEF, 0, 0, MP, 16'hBEEF};
        v[11] = '{5'd4, 5'd0, 1, 0, 5'd4, 1, 1, 1, 16'h0040, 1, 0, MH, 16'h0};
        v[12] = '{5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 16'h0080, 1, 1, MP, 16'h0080};
        v[13] = '{5'd6, 5'd6, 0, 1, 5'd5, 1, 0, 0, 16'h0,    0, 0, NO, 16'h0};
        for (int i = 0; i < 14; i++) begin
            cyc();
            pulse_rst();
            id_rs1 = v[i].rs1; id_rs2 = v[i].rs2; id_use_rs1 = v[i].u1; id_use_rs2 = v[i].u2;
            exe_rd = v[i].rd; exe_is_load = v[i].ld; exe_is_mdu = v[i].mdu;
            br_mispredict = v[i].bm; br_target = v[i].tgt;
            dmem_req = v[i].req; dmem_ready = v[i].rdy;
            @(negedge clk);
            chk($sformatf("vec%0d", i), v[i].ef, v[i].epc, 2'd0);
        end

        // memory wait masking a mispredict, then release with redirect
        cyc(); clr(); pulse_rst();
        dmem_req = 1; br_mispredict = 1; br_target = 16'h0040;
        @(negedge clk);
        chk("mem_hold_run", MH, 16'h0, 2'd0);
        for (int k = 0; k < 3; k++) begin
            cyc();
            @(negedge clk);
            chk($sformatf("mem_wait%0d", k), MH, 16'h0, 2'd1);
        end
        cyc(); dmem_ready = 1;
        @(negedge clk);
        chk("mem_release", MP, 16'h0040, 2'd1);
        cyc(); clr();
        @(negedge clk);
        chk("mem_back_run", NO, 16'h0, 2'd0);

        // full MDU occupancy
        cyc(); pulse_rst();
        exe_is_mdu = 1;
        @(negedge clk);
        chk("mdu_start", MD, 16'h0, 2'd0);
        cyc(); clr();
        br_mispredict = 1; dmem_req = 1; exe_is_load = 1; exe_rd = 5'd2; id_rs1 = 5'd2; id_use_rs1 = 1;
        for (int k = 2; k <= 8; k++) begin
            @(negedge clk);
            chk($sformatf("mdu_cyc%0d", k), (k < 8) ? MD : DN, 16'h0, 2'd2);
            cyc();
        end
        clr();
        @(negedge clk);
        chk("mdu_back_run", NO, 16'h0, 2'd0);
`ifdef HAZARD_PERF_EN
        total_n++;
        if (perf_stall_cycles == 32'd7 && perf_flush_events == 32'd7) pass_n++;
        else $display("FAIL perf_mdu: got stall=%0d flush=%0d, want 7 7", perf_stall_cycles, perf_flush_events);
`endif

        // reset during MDU occupancy aborts with no completion pulse
        cyc(); pulse_rst();
        exe_is_mdu = 1;
        cyc(); exe_is_mdu = 0;
        cyc();
        cyc();
        @(negedge clk);
        chk("mdu_cyc4_before_rst", MD, 16'h0, 2'd2);
        rst = 1'b1;
        #1;
        chk("mdu_rst_abort", NO, 16'h0, 2'd0);
`ifdef HAZARD_PERF_EN
        total_n++;
        if (perf_stall_cycles == 32'd0 && perf_flush_events == 32'd0) pass_n++;
        else $display("FAIL perf_reset: got stall=%0d flush=%0d, want 0 0", perf_stall_cycles, perf_flush_events);
`endif
        cyc();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("after_abort%0d", k), NO, 16'h0, 2'd0);
            cyc();
        end

        $display("%0d/%0d checks passed", pass_n, total_n);
        $finish;
    end
endmodule
